// File: rtl/bcd_updown_counter_n.sv
// rtl/bcd_updown_counter_n.sv - multi-digit synchronous BCD up/down counter with load and terminal count
//
// Optional build macro: BCD_UPDOWN_SAT_EN (saturate at 0..0 / 9..9 instead of wrapping)
//
// Ports:
//   clock     in   sole clock, rising edge
//   reset     in   synchronous active-low reset
//   en        in   count enable
//   down      in   0 = count up, 1 = count down
//   load      in   parallel-load strobe (beats en)
//   load_val  in   4*DIGITS, nibble i loads digit i (nibbles > 9 clamp to 9)
//   count     out  4*DIGITS, nibble i is digit i, digit 0 least significant
//   tc        out  registered terminal-count pulse
//   load_err  out  registered flag: last load carried a non-BCD nibble
module bcd_updown_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic              tc_q, tc_d;
  logic              load_err_q, load_err_d;

  // carry_in[i] / borrow_in[i]: every digit below i is 9 / 0
  logic [DIGITS-1:0] carry_in;
  logic [DIGITS-1:0] borrow_in;
  logic              all_nine;
  logic              all_zero;
  logic [W-1:0]      step_val;
  logic [W-1:0]      clamp_val;
  logic              any_bad;

  // Running AND kept in local variables so the vector bits never feed each other.
  always_comb begin
    logic run9;
    logic run0;
    run9      = 1'b1;
    run0      = 1'b1;
    carry_in  = '0;
    borrow_in = '0;
    for (int i = 0; i < DIGITS; i++) begin
      carry_in[i]  = run9;
      borrow_in[i] = run0;
      run9 = run9 & (count_q[4*i +: 4] == 4'd9);
      run0 = run0 & (count_q[4*i +: 4] == 4'd0);
    end
    all_nine = run9;
    all_zero = run0;
  end

  // One up or down step of every digit; digits without carry/borrow hold.
  always_comb begin
    step_val = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (!down && carry_in[i]) begin
        step_val[4*i +: 4] = (count_q[4*i +: 4] >= 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      end else if (down && borrow_in[i]) begin
        step_val[4*i +: 4] = ((count_q[4*i +: 4] == 4'd0) || (count_q[4*i +: 4] > 4'd9))
                             ? 4'd9 : count_q[4*i +: 4] - 4'd1;
      end
    end
  end

  // Load sanitising: out-of-range nibbles become 9 and raise the error flag.
  always_comb begin
    clamp_val = load_val;
    any_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        clamp_val[4*i +: 4] = 4'd9;
        any_bad             = 1'b1;
      end
    end
  end

  always_comb begin
    logic at_limit;
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = load_err_q;
    at_limit   = down ? all_zero : all_nine;
    if (load) begin
      count_d    = clamp_val;
      load_err_d = any_bad;
    end else if (en) begin
      tc_d = at_limit;
`ifdef BCD_UPDOWN_SAT_EN
      if (!at_limit) begin
        count_d = step_val;
      end
`else
      count_d = step_val;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb/tb_bcd_updown_counter_n.sv - directed self-checking bench for bcd_updown_counter_n
module tb_bcd_updown_counter_n;

  logic        clock;
  logic        reset;
  logic        en;
  logic        down;
  logic        load;
  logic [7:0]  load_val2;
  logic [15:0] load_val4;
  logic [7:0]  count2;
  logic [15:0] count4;
  logic        tc2, tc4;
  logic        load_err2, load_err4;

  int n_checks;
  int n_fail;

  bcd_updown_counter_n #(.DIGITS(2)) u_dut2 (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .down     (down),
    .load     (load),
    .load_val (load_val2),
    .count    (count2),
    .tc       (tc2),
    .load_err (load_err2)
  );

  bcd_updown_counter_n #(.DIGITS(4)) u_dut4 (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .down     (down),
    .load     (load),
    .load_val (load_val4),
    .count    (count4),
    .tc       (tc4),
    .load_err (load_err4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int v;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    en        = 1'b0;
    down      = 1'b0;
    load      = 1'b0;
    load_val2 = 8'h00;
    load_val4 = 16'h0000;

    // reset
    tick();
    check("rst_count2", count2, 32'h00);
    check("rst_count4", count4, 32'h0000);
    check("rst_tc2", tc2, 0);
    check("rst_err2", load_err2, 0);
    reset = 1'b1;

    // 100 up edges on 2 digits: 01..99, then 00 with tc
    en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      v = k % 100;
      check("up_count2", count2, ((v / 10) << 4) | (v % 10));
      check("up_tc2", tc2, (k == 100) ? 1 : 0);
    end

    // hold clears tc and keeps count
    en = 1'b0;
    tick();
    check("hold_count2", count2, 32'h00);
    check("hold_tc2", tc2, 0);

    // load 10 / 0000, then two down edges
    load = 1'b1; load_val2 = 8'h10; load_val4 = 16'h0000;
    tick();
    check("ld10_count2", count2, 32'h10);
    check("ld10_tc2", tc2, 0);
    check("ld0_count4", count4, 32'h0000);
    load = 1'b0; en = 1'b1; down = 1'b1;
    tick();
    check("dn1_count2", count2, 32'h09);
    check("dn1_tc2", tc2, 0);
    check("dn1_count4", count4, 32'h9999);
    check("dn1_tc4", tc4, 1);
    tick();
    check("dn2_count2", count2, 32'h08);
    check("dn2_tc2", tc2, 0);
    check("dn2_count4", count4, 32'h9998);
    check("dn2_tc4", tc4, 0);

    // multi-digit carry / borrow ripple
    en = 1'b0; load = 1'b1; load_val4 = 16'h0999;
    tick();
    load = 1'b0; en = 1'b1; down = 1'b0;
    tick();
    check("carry_count4", count4, 32'h1000);
    check("carry_tc4", tc4, 0);
    down = 1'b1;
    tick();
    check("borrow_count4", count4, 32'h0999);

    // clamp on load
    en = 1'b0; load = 1'b1; load_val4 = 16'h9A3F; load_val2 = 8'h3C;
    tick();
    check("clamp_count4", count4, 32'h9939);
    check("clamp_err4", load_err4, 1);
    check("clamp_count2", count2, 32'h39);
    check("clamp_err2", load_err2, 1);
    load = 1'b0; en = 1'b1; down = 1'b0;
    tick(); tick(); tick();
    check("err_keep_count2", count2, 32'h42);
    check("err_keep_err2", load_err2, 1);
    en = 1'b0; load = 1'b1; load_val2 = 8'h05;
    tick();
    check("err_clr_count2", count2, 32'h05);
    check("err_clr_err2", load_err2, 0);

    // reset beats load and en on the same edge
    load_val2 = 8'hAA;
    tick();
    check("ldAA_count2", count2, 32'h99);
    check("ldAA_err2", load_err2, 1);
    reset = 1'b0; load = 1'b1; en = 1'b1; load_val2 = 8'h55;
    tick();
    check("rstld_count2", count2, 32'h00);
    check("rstld_tc2", tc2, 0);
    check("rstld_err2", load_err2, 0);
    reset = 1'b1; en = 1'b0;
    tick();
    check("ld55_count2", count2, 32'h55);

    // limit behaviour from 98
    load_val2 = 8'h98;
    tick();
    load = 1'b0; en = 1'b1; down = 1'b0;
    tick();
    check("lim1_count2", count2, 32'h99);
    check("lim1_tc2", tc2, 0);
    tick();
`ifdef BCD_UPDOWN_SAT_EN
    check("lim2_count2", count2, 32'h99);
    check("lim2_tc2", tc2, 1);
    tick();
    check("lim3_count2", count2, 32'h99);
    check("lim3_tc2", tc2, 1);
`else
    check("lim2_count2", count2, 32'h00);
    check("lim2_tc2", tc2, 1);
    tick();
    check("lim3_count2", count2, 32'h01);
    check("lim3_tc2", tc2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
# bcd_updown_counter_n

Parametrised multi-digit synchronous BCD up/down counter. It generalises the team's single-digit BCD up/down counter to `DIGITS` cascaded decades, and adds count enable, parallel load, a terminal-count pulse and load validation. It sits in the display and timekeeping path and drives the BCD-to-seven-segment decoders directly. One digit occupies one nibble; digit 0 is the least-significant decade.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD decades, legal range 1..8. Counter width is 4*DIGITS.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `en`  in  1  count enable; the counter holds when low.
- `down`  in  1  direction: 0 = count up, 1 = count down. Same sense as the single-digit counter.
- `load`  in  1  parallel-load strobe.
- `load_val`  in  4*DIGITS  value to load; nibble i is digit i.
- `count`  out  4*DIGITS  current count; nibble i is digit i.
- `tc`  out  1  terminal-count pulse, registered.
- `load_err`  out  1  set when a loaded nibble was not valid BCD, registered.

## Operation

- Priority on each rising edge: `reset` low > `load` > `en` > hold.
- Reset (`reset`=0) clears `count` to all zeros and clears `tc` and `load_err` to 0.
- Load (`load`=1):
  - Each nibble of `load_val` that is ≤9 is copied into the matching digit.
  - Each nibble >9 is written as 9.
  - `load_err` is set to 1 if any nibble was >9, otherwise 0.
  - `tc` is set to 0.
  - `en` and `down` are ignored in that cycle.
- Count up (`en`=1, `down`=0):
  - Digit 0 increments.
  - A digit at 9 with carry-in becomes 0 and passes carry to the next digit.
  - Digit i has carry-in when all lower digits are 9.
- Count down (`en`=1, `down`=1):
  - Digit 0 decrements.
  - A digit at 0 with borrow-in becomes 9 and passes borrow to the next digit.
  - Digit i has borrow-in when all lower digits are 0.
- Wrap (default build, see Configuration):
  - Up from all-9s (e.g. 9999) gives 0000, with `tc`=1 for that cycle.
  - Down from 0000 gives 9999, with `tc`=1 for that cycle.
- `tc` is 0 on every other edge, including hold, load and non-wrapping counts.
- `load_err`:
  - Retains its value through count and hold cycles.
  - Is updated only by a load or by reset.
- Digits never hold a value >9 under any input sequence.
- A direction change takes effect on the next enabled edge. There is no pipeline, so nothing needs draining.
- Reset asserted mid-count overrides `load` and `en` in the same edge.

## Timing

- All outputs are flops; there is no combinational path from any input to any output.
- Load latency: `load_val` appears on `count` one cycle after the `load` edge. `load_err` is valid in the same cycle.
- Count latency: one step per enabled edge. All carries ripple within one cycle; there is no multi-cycle carry.
- `tc` is high for exactly one cycle, coincident with `count` showing the wrapped value.
- Reset takes effect on the first rising edge with `reset`=0. Outputs are at reset values from the following cycle.
- Critical path: DIGITS-deep all-9s / all-0s detect chain. It must meet timing at DIGITS=8.

## Configuration

- Macro: `BCD_UPDOWN_SAT_EN`.
- Defined: the counter saturates instead of wrapping.
  - Up at all-9s holds all-9s.
  - Down at 0000 holds 0000.
  - `tc` is 1 on every enabled edge that is blocked at the limit, so it stays high while `en` is held there.
  - `tc` is 0 otherwise.
  - Load and reset behaviour are unchanged.
- Not defined: wrap behaviour as described in Operation.
- Port list is identical in both builds.

## Test plan

- DIGITS=2, reset low for 1 edge, then `en`=1, `down`=0 for 100 edges: `count` steps 00→01→…→99→00. `tc`=1 only on the cycle showing 00 after 99.
- DIGITS=2, load 0x10, then `en`=1, `down`=1 for 2 edges: `count` shows 10, then 09, then 08. `tc`=0 throughout.
- DIGITS=4, load 0x0000, one down edge: `count`=9999, `tc`=1. Next down edge: `count`=9998, `tc`=0.
- DIGITS=2, load 0x3C: `count`=39, `load_err`=1. Then 3 up edges: `count`=42 and `load_err` still 1. Then load 0x05: `load_err`=0.
- DIGITS=2, `load`=1 with `load_val`=0x55, `en`=1 and `reset`=0 on the same edge: `count`=00, `tc`=0, `load_err`=0. Next edge with only `load`: `count`=55.
- With `BCD_UPDOWN_SAT_EN`, DIGITS=2, load 0x98, 3 up edges: `count`=99, 99, 99. `tc` goes 0, 1, 1.
